// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the instruction memory. A byte stream arriving on a
// valid/ready interface is assembled into little-endian 32-bit words and
// written into the instruction RAM at consecutive word indices, starting at
// BASE_WORD and wrapping modulo 2**AW. While a load is in progress busy is
// high and the CPU must be held in reset.
//
// Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes.
// Byte 0 of each word lands in wdata[7:0], byte 3 in wdata[31:24].
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the data. It must equal the XOR of
//   all 4*N data bytes; a match ends in done, a mismatch in err. The words
//   are written in either case.
//
// Parameters:
//   AW         word-address width, memory depth is 2**AW words
//   BASE_WORD  word index of the first loaded instruction
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         single-cycle pulse, begins a load when idle
//   in_valid      byte-stream valid
//   in_data       byte-stream data
//   in_ready      byte accepted when in_valid && in_ready at a rising edge
//   mem_we        instruction RAM write strobe, one cycle per word
//   mem_addr      word index being written
//   mem_wdata     instruction word being written
//   busy          load in progress
//   done          sticky, image loaded successfully
//   err           sticky, bad length or bad checksum
//   words_loaded  number of words written during the current load
// -----------------------------------------------------------------------------
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for start, stream not accepted
// LEN_LO  | accepting low byte of word count
// LEN_HI  | accepting high byte of word count, range check
// DATA    | accepting data bytes into the assembly register
// WRITE   | one-cycle RAM write of the assembled word
// CHK     | accepting the checksum byte (checksum build only)
// FIN     | load complete, done raised, returns to IDLE
// ERR     | load rejected, err raised, returns to IDLE

module imem_loader #(
  parameter int AW        = 10,
  parameter int BASE_WORD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_FIN,
    S_ERR
  } state_t;

  localparam int            DEPTH     = 1 << AW;
  // Truncation to AW bits makes any BASE_WORD behave modulo the depth.
  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE_WORD);

  state_t        state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [1:0]    byte_cnt;
  // Only three bytes need storing; the fourth comes straight from in_data.
  logic [23:0]   asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic          accept;
  logic [15:0]   len_rx;
  logic          len_bad;
  logic          last_word;
  logic [AW-1:0] wr_addr;

  always_comb begin
    accept    = in_valid && in_ready;
    len_rx    = {in_data, len_lo};
    len_bad   = (len_rx == 16'd0) || (32'(len_rx) > DEPTH);
    last_word = ((17'(words_loaded) + 17'd1) == {1'b0, len});
    wr_addr   = BASE_ADDR + words_loaded[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len_lo       <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LEN_LO;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len      <= len_rx;
            byte_cnt <= '0;
            if (len_bad) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (byte_cnt == 2'd3) begin
              // Write strobe is registered here so it appears in the cycle
              // right after the fourth byte is taken.
              state     <= S_WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= {in_data, asm_word};
              byte_cnt  <= '0;
            end else begin
              asm_word <= {in_data, asm_word[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        S_WRITE: begin
          words_loaded <= words_loaded + (AW+1)'(1);
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CHK;
            in_ready <= 1'b1;
`else
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else begin
            state    <= S_DATA;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif

        // FIN and ERR last one cycle so a start arriving as the load
        // finishes is not mistaken for a new request.
        S_FIN:   state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
